// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants and the hash-state controller's FSM encoding.
package sha256_pkg;

  localparam int unsigned SHA_WORD_W = 32;
  localparam int unsigned SHA_ROUNDS = 64;
  localparam int unsigned SHA_IDX_W  = 6;

  // Index 7 is H0 so the packed value matches the {H0..H7} bus ordering.
  localparam logic [7:0][31:0] SHA256_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    RUN   = 2'd2,
    ACCUM = 2'd3
  } hash_state_e;

endpackage

// File: rtl/sha256_h_accum.sv
// Running hash words H0..H7: load the IV on init, add the core's working variables on accum.
module sha256_h_accum
  import sha256_pkg::*;
#(
  parameter int unsigned WORD_W = SHA_WORD_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init,
  input  logic                  accum,
  input  logic [8*WORD_W-1:0]   wv_result,
  output logic [8*WORD_W-1:0]   h_state,
  output logic [8*WORD_W-1:0]   h_sum
);

  logic [8*WORD_W-1:0] iv_flat;

  // Each word adds independently; the carry out of a word is dropped.
  always_comb begin
    iv_flat = '0;
    h_sum   = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      iv_flat[i*WORD_W +: WORD_W] = WORD_W'(SHA256_IV[i]);
      h_sum[i*WORD_W +: WORD_W]   = h_state[i*WORD_W +: WORD_W] + wv_result[i*WORD_W +: WORD_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst || init) begin
      h_state <= iv_flat;
    end else if (accum) begin
      h_state <= h_sum;
    end
  end

endmodule

// File: rtl/sha256_hash_state_ctrl.sv
// Block sequencer for the SHA-256 compression datapath: block handshake, round stepping,
// hash-state initialisation and final digest capture.
module sha256_hash_state_ctrl
  import sha256_pkg::*;
#(
  parameter int unsigned WORD_W = SHA_WORD_W,
  parameter int unsigned ROUNDS = SHA_ROUNDS,
  parameter int unsigned IDX_W  = SHA_IDX_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  blk_valid,
  input  logic                  blk_first,
  input  logic                  blk_last,
  output logic                  blk_ready,
  input  logic                  abort,
  output logic                  wv_load,
  output logic                  round_en,
  output logic [IDX_W-1:0]      round_idx,
  input  logic [8*WORD_W-1:0]   wv_result,
  output logic [8*WORD_W-1:0]   h_state,
  output logic [8*WORD_W-1:0]   digest,
  output logic                  digest_valid,
  output logic                  seq_err
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ROUNDS - 1);

  hash_state_e          state, state_next;
  logic [IDX_W-1:0]     round_cnt;
  logic                 msg_open;
  logic                 last_q;
  logic                 accept;
  logic                 init_h;
  logic                 accum_h;
  logic [8*WORD_W-1:0]  h_sum;

  // abort wins over acceptance and suppresses the accumulate.
  assign accept  = blk_valid && (state == IDLE) && !abort;
  assign init_h  = accept && (blk_first || !msg_open);
  assign accum_h = (state == ACCUM) && !abort;

  sha256_h_accum #(.WORD_W(WORD_W)) u_h_accum (
    .clk       (clk),
    .rst       (rst),
    .init      (init_h),
    .accum     (accum_h),
    .wv_result (wv_result),
    .h_state   (h_state),
    .h_sum     (h_sum)
  );

  always_comb begin
    state_next = state;
    blk_ready  = 1'b0;
    wv_load    = 1'b0;
    round_en   = 1'b0;
    round_idx  = '0;
    case (state)
      IDLE: begin
        blk_ready = 1'b1;
        if (accept) state_next = LOAD;
      end
      LOAD: begin
        wv_load    = 1'b1;
        state_next = RUN;
      end
      RUN: begin
        round_en  = 1'b1;
        round_idx = round_cnt;
        if (round_cnt == LAST_IDX) state_next = ACCUM;
      end
      ACCUM:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort) state_next = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      round_cnt    <= '0;
      msg_open     <= 1'b0;
      last_q       <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      seq_err      <= 1'b0;
    end else begin
      state        <= state_next;
      digest_valid <= 1'b0;
      seq_err      <= 1'b0;
      if (state == RUN && !abort && round_cnt != LAST_IDX) round_cnt <= round_cnt + 1'b1;
      else                                                 round_cnt <= '0;
      if (abort) begin
        msg_open <= 1'b0;
      end else if (accept) begin
        msg_open <= 1'b1;
        last_q   <= blk_last;
        // first-while-open restarts; non-first-while-closed starts fresh; both flag an error
        seq_err  <= (blk_first == msg_open);
      end else if (state == ACCUM && last_q) begin
        msg_open     <= 1'b0;
        digest       <= h_sum;
        digest_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_sha256_hash_state_ctrl.sv
// Self-checking bench: reference round core drives wv_result, a plain SHA-256 model predicts H/digest.
module tb_sha256_hash_state_ctrl;

  typedef logic [0:15][31:0] blk_t;
  typedef logic [0:63][31:0] sched_t;
  typedef logic [7:0][31:0]  st_t;

  localparam logic [255:0] IV = {32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                                 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] ABC_DIG = {32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                                      32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};
  localparam logic [255:0] TWO_DIG = {32'h248d6a61, 32'hd20638b8, 32'he5c02693, 32'h0c3e6039,
                                      32'ha33ce459, 32'h64ff2167, 32'hf6ecedd4, 32'h19db06c1};
  localparam logic [0:63][31:0] K = {
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  localparam blk_t ABC_BLK = {32'h61626380, {14{32'h0}}, 32'h00000018};
  localparam blk_t TWO_B1  = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                              32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                              32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                              32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
  localparam blk_t TWO_B2  = {{15{32'h0}}, 32'h000001c0};

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         blk_valid = 1'b0, blk_first = 1'b0, blk_last = 1'b0, abort = 1'b0;
  logic         blk_ready, wv_load, round_en, digest_valid, seq_err;
  logic [5:0]   round_idx;
  logic [255:0] wv_result, h_state, digest;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  st_t    core = '0;
  sched_t wsch = '0;
  blk_t   cur_blk = '0;
  bit     force_ones = 1'b0;
  logic [255:0] ref_h, ref_digest;
  bit     ref_open;

  sha256_hash_state_ctrl #(.WORD_W(32), .ROUNDS(64), .IDX_W(6)) dut (
    .clk(clk), .rst(rst), .blk_valid(blk_valid), .blk_first(blk_first), .blk_last(blk_last),
    .blk_ready(blk_ready), .abort(abort), .wv_load(wv_load), .round_en(round_en),
    .round_idx(round_idx), .wv_result(wv_result), .h_state(h_state), .digest(digest),
    .digest_valid(digest_valid), .seq_err(seq_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic sched_t schedule(input blk_t b);
    sched_t w;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) w[t] = b[t];
      else w[t] = (rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10)) + w[t-7]
                + (rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3)) + w[t-16];
    end
    return w;
  endfunction

  function automatic st_t sha_round(input st_t s, input logic [31:0] k, input logic [31:0] w);
    logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
    {a, b, c, d, e, f, g, h} = s;
    t1 = h + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + k + w;
    t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
    return {t1 + t2, a, b, c, d + t1, e, f, g};
  endfunction

  function automatic st_t add_words(input st_t x, input st_t y);
    st_t r;
    for (int i = 0; i < 8; i++) r[i] = x[i] + y[i];
    return r;
  endfunction

  function automatic st_t compress(input st_t hin, input blk_t b);
    sched_t w;
    st_t s;
    w = schedule(b);
    s = hin;
    for (int t = 0; t < 64; t++) s = sha_round(s, K[t], w[t]);
    return add_words(hin, s);
  endfunction

  function automatic blk_t rand_blk();
    blk_t b;
    for (int i = 0; i < 16; i++) b[i] = $urandom;
    return b;
  endfunction

  // Reference round core standing in for the datapath.
  always @(posedge clk) begin
    if (wv_load) begin
      core <= h_state;
      wsch <= schedule(cur_blk);
    end else if (round_en) begin
      core <= sha_round(core, K[round_idx], wsch[round_idx]);
    end
  end
  assign wv_result = force_ones ? '1 : core;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0; abort = 1'b0; force_ones = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ref_h = IV; ref_open = 1'b0; ref_digest = '0;
    @(negedge clk);
  endtask

  task automatic accept_block(input bit first, input bit last, input blk_t b);
    cur_blk = b; blk_first = first; blk_last = last; blk_valid = 1'b1;
    for (int n = 0; n < 200 && blk_ready !== 1'b1; n++) @(negedge clk);
    checks++;
    if (blk_ready !== 1'b1) begin
      errors++; $display("FAIL accept_timeout: blk_ready=%b required 1", blk_ready);
    end
    @(negedge clk);
    blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
  endtask

  // Offers one block and checks the whole LOAD/RUN/ACCUM/IDLE sequence against the model.
  task automatic process_block(input bit first, input bit last, input blk_t b, input bit force_wv);
    logic [255:0] pre, post;
    bit exp_err;
    exp_err = (first == ref_open);
    pre  = (first || !ref_open) ? IV : ref_h;
    post = force_wv ? add_words(pre, '1) : compress(pre, b);
    accept_block(first, last, b);
    force_ones = force_wv;
    checks++;
    if (wv_load !== 1'b1 || blk_ready !== 1'b0 || round_en !== 1'b0 || seq_err !== exp_err || h_state !== pre) begin
      errors++;
      $display("FAIL load_cycle: wv_load=%b ready=%b round_en=%b seq_err=%b h=%h required 1 0 0 %b h=%h",
               wv_load, blk_ready, round_en, seq_err, h_state, exp_err, pre);
    end
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      checks++;
      if (round_en !== 1'b1 || round_idx !== 6'(i) || wv_load !== 1'b0 || (i == 0 && seq_err !== 1'b0)) begin
        errors++;
        $display("FAIL run_round: round_en=%b round_idx=%0d wv_load=%b seq_err=%b required 1 %0d 0 0",
                 round_en, round_idx, wv_load, seq_err, i);
      end
    end
    @(negedge clk);
    checks++;
    if (round_en !== 1'b0 || round_idx !== 6'd0 || wv_load !== 1'b0 || blk_ready !== 1'b0 || digest_valid !== 1'b0) begin
      errors++;
      $display("FAIL accum_cycle: round_en=%b idx=%0d wv_load=%b ready=%b dv=%b required 0 0 0 0 0",
               round_en, round_idx, wv_load, blk_ready, digest_valid);
    end
    @(negedge clk);
    force_ones = 1'b0;
    ref_h = post;
    ref_open = !last;
    if (last) ref_digest = post;
    checks++;
    if (h_state !== post || digest_valid !== last || blk_ready !== 1'b1 || digest !== ref_digest) begin
      errors++;
      $display("FAIL idle_result: h=%h dv=%b ready=%b digest=%h required h=%h dv=%b ready=1 digest=%h",
               h_state, digest_valid, blk_ready, digest, post, last, ref_digest);
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (h_state !== IV || digest !== '0 || digest_valid !== 1'b0 || seq_err !== 1'b0 ||
        wv_load !== 1'b0 || round_en !== 1'b0 || round_idx !== 6'd0 || blk_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: h=%h digest=%h dv=%b se=%b wl=%b re=%b idx=%0d ready=%b required IV 0 0 0 0 0 0 1",
               h_state, digest, digest_valid, seq_err, wv_load, round_en, round_idx, blk_ready);
    end
  endtask

  task automatic test_abc();
    do_reset();
    process_block(1'b1, 1'b1, ABC_BLK, 1'b0);
    checks++;
    if (digest !== ABC_DIG) begin
      errors++; $display("FAIL abc_digest: got %h required %h", digest, ABC_DIG);
    end
  endtask

  task automatic test_two_block();
    do_reset();
    process_block(1'b1, 1'b0, TWO_B1, 1'b0);
    process_block(1'b0, 1'b1, TWO_B2, 1'b0);
    checks++;
    if (digest !== TWO_DIG) begin
      errors++; $display("FAIL two_block_digest: got %h required %h", digest, TWO_DIG);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    process_block(1'b1, 1'b0, rand_blk(), 1'b1);
    checks++;
    if (h_state[255:224] !== 32'h6a09e666 || h_state[31:0] !== 32'h5be0cd18 || $isunknown(h_state)) begin
      errors++; $display("FAIL wrap_add: H0=%h H7=%h required 6a09e666 5be0cd18", h_state[255:224], h_state[31:0]);
    end
  endtask

  task automatic test_abort();
    bit seen_dv;
    do_reset();
    accept_block(1'b1, 1'b1, ABC_BLK);
    for (int n = 0; n < 100 && !(round_en === 1'b1 && round_idx === 6'd30); n++) @(negedge clk);
    checks++;
    if (round_idx !== 6'd30) begin
      errors++; $display("FAIL abort_reach_round30: round_idx=%0d required 30", round_idx);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    ref_h = IV; ref_open = 1'b0;
    checks++;
    if (round_en !== 1'b0 || wv_load !== 1'b0 || blk_ready !== 1'b1 || digest_valid !== 1'b0 ||
        h_state !== IV || digest !== '0) begin
      errors++;
      $display("FAIL abort_next_cycle: re=%b wl=%b ready=%b dv=%b h=%h digest=%h required 0 0 1 0 IV 0",
               round_en, wv_load, blk_ready, digest_valid, h_state, digest);
    end
    seen_dv = 1'b0;
    repeat (70) begin
      @(negedge clk);
      if (digest_valid === 1'b1 || round_en === 1'b1) seen_dv = 1'b1;
    end
    checks++;
    if (seen_dv) begin
      errors++; $display("FAIL abort_quiet: activity=1 required 0");
    end
    process_block(1'b1, 1'b1, ABC_BLK, 1'b0);
    checks++;
    if (digest !== ABC_DIG) begin
      errors++; $display("FAIL abort_then_abc: got %h required %h", digest, ABC_DIG);
    end
  endtask

  task automatic test_seq_err();
    do_reset();
    process_block(1'b0, 1'b1, ABC_BLK, 1'b0);
    checks++;
    if (digest !== ABC_DIG) begin
      errors++; $display("FAIL nonfirst_as_first: got %h required %h", digest, ABC_DIG);
    end
    process_block(1'b1, 1'b0, rand_blk(), 1'b0);
    process_block(1'b1, 1'b1, ABC_BLK, 1'b0);
    checks++;
    if (digest !== ABC_DIG) begin
      errors++; $display("FAIL restart_digest: got %h required %h", digest, ABC_DIG);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 8; i++)
      process_block(($urandom % 4) == 0, ($urandom % 3) == 0, rand_blk(), 1'b0);
  endtask

  task automatic test_back_to_back();
    blk_t blks [3];
    int   acc [3];
    int   idx, since;
    logic [255:0] exp_h;
    do_reset();
    for (int i = 0; i < 3; i++) blks[i] = rand_blk();
    exp_h = compress(compress(compress(IV, blks[0]), blks[1]), blks[2]);
    acc = '{0, 0, 0};
    idx = 0; since = 99;
    cur_blk = blks[0]; blk_first = 1'b1; blk_last = 1'b0; blk_valid = 1'b1;
    for (int n = 0; n < 400 && idx < 3; n++) begin
      if (blk_valid && blk_ready === 1'b1) begin acc[idx] = cyc; idx++; since = 0; end
      @(negedge clk);
      since++;
      if (since == 1) begin
        if (idx == 3) blk_valid = 1'b0;
        else begin blk_first = 1'b0; blk_last = (idx == 2); end
      end
      if (since == 2 && idx < 3) cur_blk = blks[idx];
    end
    blk_valid = 1'b0; blk_first = 1'b0; blk_last = 1'b0;
    checks++;
    if (idx != 3 || acc[1] - acc[0] != 67 || acc[2] - acc[1] != 67) begin
      errors++; $display("FAIL b2b_spacing: accepts=%0d gaps=%0d,%0d required 3 gaps 67,67",
                         idx, acc[1] - acc[0], acc[2] - acc[1]);
    end
    repeat (66) @(negedge clk);
    checks++;
    if (digest_valid !== 1'b1 || digest !== exp_h || h_state !== exp_h) begin
      errors++; $display("FAIL b2b_digest: dv=%b digest=%h h=%h required 1 %h", digest_valid, digest, h_state, exp_h);
    end
    accept_block(1'b1, 1'b1, rand_blk());
    repeat (65) @(negedge clk);
    checks++;
    if (round_en !== 1'b0 || wv_load !== 1'b0 || blk_ready !== 1'b0) begin
      errors++; $display("FAIL rst_accum_reach: re=%b wl=%b ready=%b required 0 0 0", round_en, wv_load, blk_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (h_state !== IV || digest !== '0 || digest_valid !== 1'b0 || blk_ready !== 1'b1) begin
      errors++; $display("FAIL rst_in_accum: h=%h digest=%h dv=%b ready=%b required IV 0 0 1",
                         h_state, digest, digest_valid, blk_ready);
    end
    ref_h = IV; ref_open = 1'b0; ref_digest = '0;
  endtask

  initial begin
    test_reset();
    test_abc();
    test_two_block();
    test_wrap();
    test_abort();
    test_seq_err();
    test_random();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
